// File: rtl/req_capture_83_pkg.sv
// req_capture_83_pkg
//   Shared definitions for the request-capture stage that feeds the 8:3
//   priority encoder. Contents:
//     N_REQ, CODE_W : request width and code width
//     state_e       : presentation FSM encoding (IDLE / PRESENT)
//     hi_index()    : index of the highest set bit (bit 7 wins), 0 if none
package req_capture_83_pkg;

   localparam int N_REQ  = 8;
   localparam int CODE_W = 3;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_e;

   // Same priority order as the downstream encoder. An all-zero input
   // returns 0.
   function automatic logic [CODE_W-1:0] hi_index(input logic [N_REQ-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = '0;
      // Ascending scan, so the highest set bit is the last one written.
      for (int i = 0; i < N_REQ; i++) begin
         if (v[i]) idx = CODE_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/req_capture_83_sync_edge.sv
// req_sync_edge
//   Synchronizer for the eight asynchronous request lines, followed by an
//   edge detector (EDGE_MODE=1) or a level pass-through (EDGE_MODE=0).
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     req_i[7:0] : raw asynchronous request lines
//     cap_o[7:0] : capture strobe, one cycle per rising edge (edge mode) or
//                  high on every cycle the synchronized bit is high (level mode)
module req_sync_edge
   import req_capture_83_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_MODE   = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_i,
   output logic [N_REQ-1:0] cap_o
);

   logic [N_REQ-1:0] sync_q [SYNC_STAGES];
   logic [N_REQ-1:0] hist_q;

   // The chain resets to 0, so a line held high across reset release is
   // seen as exactly one rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         hist_q <= '0;
      end else begin
         sync_q[0] <= req_i;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   generate
      if (EDGE_MODE) begin : g_edge
         assign cap_o = sync_q[SYNC_STAGES-1] & ~hist_q;
      end else begin : g_level
         assign cap_o = sync_q[SYNC_STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/req_capture_83.sv
// req_capture_83
//   Request-capture stage ahead of the 8:3 priority encoder. Latches
//   synchronized request edges into a pending mask and presents the
//   highest-priority pending index on a valid/ready handshake.
//   Handshake: code_o is stable while valid_o=1; a transfer happens on a
//   rising clock edge with valid_o=1 and ready_i=1. After a transfer the
//   FSM spends one cycle in IDLE before presenting again. ready_i is
//   ignored while valid_o=0.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     req_i[7:0]  : asynchronous request lines, bit 7 highest priority
//     en_i        : presentation enable (capture continues while low)
//     ready_i     : consumer accepts the presented code
//     clr_ovf_i   : synchronous clear of all overflow flags
//     pend_o[7:0] : registered pending mask (encoder d inputs)
//     code_o[2:0] : registered index being presented
//     valid_o     : code_o is valid
//     ovf_o[7:0]  : sticky per-bit overflow flags
//     state_o     : current FSM state, for observation
module req_capture_83
   import req_capture_83_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE_MODE   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req_i,
   input  logic              en_i,
   input  logic              ready_i,
   input  logic              clr_ovf_i,
   output logic [N_REQ-1:0]  pend_o,
   output logic [CODE_W-1:0] code_o,
   output logic              valid_o,
   output logic [N_REQ-1:0]  ovf_o,
   output state_e            state_o
);

   logic [N_REQ-1:0]  cap;
   logic [N_REQ-1:0]  clr_mask;
   logic [N_REQ-1:0]  pend_q, pend_d;
   logic [N_REQ-1:0]  ovf_q, ovf_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              valid_q, valid_d;
   logic              accept;
   state_e            state_q, state_d;

   req_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_MODE   (EDGE_MODE)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .req_i (req_i),
      .cap_o (cap)
   );

   assign accept   = (state_q == PRESENT) && ready_i;
   assign clr_mask = accept ? (N_REQ'(1) << code_q) : '0;

   // A capture in the same cycle as the clear wins; the bit stays pending.
   // Overflow is only flagged when the bit was pending and is not being
   // served this cycle.
   always_comb begin
      pend_d = (pend_q & ~clr_mask) | cap;
      ovf_d  = (clr_ovf_i ? '0 : ovf_q) | (cap & pend_q & ~clr_mask);
   end

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (en_i && (pend_q != '0)) begin
               code_d  = hi_index(pend_q);
               valid_d = 1'b1;
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            // No preemption: code holds until the consumer takes it.
            if (ready_i) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         ovf_q   <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         code_q  <= code_d;
         valid_q <= valid_d;
      end
   end

   assign pend_o  = pend_q;
   assign ovf_o   = ovf_q;
   assign code_o  = code_q;
   assign valid_o = valid_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_req_capture_83.sv
// tb_req_capture_83
//   Directed bench for req_capture_83 (SYNC_STAGES=2, EDGE_MODE=1).
//   Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_req_capture_83;
   import req_capture_83_pkg::*;

   logic              clk;
   logic              rst_n;
   logic [N_REQ-1:0]  req_i;
   logic              en_i;
   logic              ready_i;
   logic              clr_ovf_i;
   logic [N_REQ-1:0]  pend_o;
   logic [CODE_W-1:0] code_o;
   logic              valid_o;
   logic [N_REQ-1:0]  ovf_o;
   state_e            state_o;

   int n_checks = 0;
   int n_fail   = 0;

   req_capture_83 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_i     (req_i),
      .en_i      (en_i),
      .ready_i   (ready_i),
      .clr_ovf_i (clr_ovf_i),
      .pend_o    (pend_o),
      .code_o    (code_o),
      .valid_o   (valid_o),
      .ovf_o     (ovf_o),
      .state_o   (state_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // One-cycle request pulse: high across exactly one rising edge.
   task automatic pulse(input logic [N_REQ-1:0] mask);
      req_i = mask;
      tick();
      req_i = '0;
   endtask

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input logic [7:0] e_pend, input logic e_valid,
                            input logic [2:0] e_code, input logic [7:0] e_ovf);
      check({tag, "_pend"},  32'(pend_o),  32'(e_pend));
      check({tag, "_valid"}, 32'(valid_o), 32'(e_valid));
      check({tag, "_code"},  32'(code_o),  32'(e_code));
      check({tag, "_ovf"},   32'(ovf_o),   32'(e_ovf));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n     = 1'b0;
      req_i     = '0;
      en_i      = 1'b1;
      ready_i   = 1'b0;
      clr_ovf_i = 1'b0;
      ticks(3);
      check_out("reset", 8'h00, 1'b0, 3'd0, 8'h00);
      check("reset_state", 32'(state_o), 32'(IDLE));
      rst_n = 1'b1;

      // 1) quiet after reset, then single-pulse latency
      for (int i = 0; i < 10; i++) begin
         tick();
         check_out("quiet", 8'h00, 1'b0, 3'd0, 8'h00);
      end
      pulse(8'h04);                                   // edge 1
      tick();                                         // edge 2
      check_out("lat_e2", 8'h00, 1'b0, 3'd0, 8'h00);
      tick();                                         // edge 3
      check_out("lat_e3", 8'h04, 1'b0, 3'd0, 8'h00);
      tick();                                         // edge 4
      check_out("lat_e4", 8'h04, 1'b1, 3'd2, 8'h00);
      check("lat_state", 32'(state_o), 32'(PRESENT));
      ready_i = 1'b1;
      tick();
      check_out("lat_acc", 8'h00, 1'b0, 3'd2, 8'h00);
      ready_i = 1'b0;
      ticks(2);

      // 2) two pending bits served in priority order with one IDLE gap
      ready_i = 1'b1;
      pulse(8'h24);
      ticks(2);
      check_out("pri_set", 8'h24, 1'b0, 3'd2, 8'h00);
      tick();
      check_out("pri_p5", 8'h24, 1'b1, 3'd5, 8'h00);
      tick();
      check_out("pri_a5", 8'h04, 1'b0, 3'd5, 8'h00);
      tick();
      check_out("pri_p2", 8'h04, 1'b1, 3'd2, 8'h00);
      tick();
      check_out("pri_a2", 8'h00, 1'b0, 3'd2, 8'h00);
      tick();
      check_out("pri_end", 8'h00, 1'b0, 3'd2, 8'h00);
      ready_i = 1'b0;

      // 3) no preemption by a higher-priority arrival
      pulse(8'h02);
      ticks(3);
      check_out("np_p1", 8'h02, 1'b1, 3'd1, 8'h00);
      pulse(8'h80);
      ticks(4);
      check_out("np_hold", 8'h82, 1'b1, 3'd1, 8'h00);
      ready_i = 1'b1;
      tick();
      check_out("np_a1", 8'h80, 1'b0, 3'd1, 8'h00);
      tick();
      check_out("np_p7", 8'h80, 1'b1, 3'd7, 8'h00);
      tick();
      check_out("np_a7", 8'h00, 1'b0, 3'd7, 8'h00);
      ready_i = 1'b0;

      // 4) en low blocks presentation but not capture
      en_i = 1'b0;
      pulse(8'h40);
      ticks(5);
      check_out("en_blk", 8'h40, 1'b0, 3'd7, 8'h00);
      en_i = 1'b1;
      tick();
      check_out("en_p6", 8'h40, 1'b1, 3'd6, 8'h00);
      en_i = 1'b0;
      tick();
      check_out("en_hold", 8'h40, 1'b1, 3'd6, 8'h00);
      en_i    = 1'b1;
      ready_i = 1'b1;
      tick();
      check_out("en_a6", 8'h00, 1'b0, 3'd6, 8'h00);
      ready_i = 1'b0;

      // 5) accept and re-capture of the same bit in one cycle: set wins
      pulse(8'h08);
      ticks(3);
      check_out("sw_p3", 8'h08, 1'b1, 3'd3, 8'h00);
      pulse(8'h08);                                   // a1
      tick();                                         // a2, strobe now high
      ready_i = 1'b1;
      tick();                                         // a3, accept + capture
      check_out("sw_acc", 8'h08, 1'b0, 3'd3, 8'h00);
      tick();
      check_out("sw_rep", 8'h08, 1'b1, 3'd3, 8'h00);
      tick();
      check_out("sw_a3", 8'h00, 1'b0, 3'd3, 8'h00);
      ready_i = 1'b0;

      // 6) overflow, clear, asynchronous reset mid-PRESENT
      pulse(8'h10);
      ticks(3);
      check_out("ov_p4", 8'h10, 1'b1, 3'd4, 8'h00);
      pulse(8'h10);
      ticks(2);
      check_out("ov_set", 8'h10, 1'b1, 3'd4, 8'h10);
      ticks(2);
      check("ov_sticky", 32'(ovf_o), 32'h10);
      clr_ovf_i = 1'b1;
      tick();
      clr_ovf_i = 1'b0;
      check_out("ov_clr", 8'h10, 1'b1, 3'd4, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("arst", 8'h00, 1'b0, 3'd0, 8'h00);
      check("arst_state", 32'(state_o), 32'(IDLE));
      tick();
      rst_n = 1'b1;
      ticks(4);
      check_out("post_rst", 8'h00, 1'b0, 3'd0, 8'h00);

      // ---------------- report ----------------
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/req_capture_83.md
Name: req_capture_83

Overview:
- Request-capture stage directly upstream of the 8:3 priority encoder.
- Synchronizes eight asynchronous request lines and latches rising edges into a pending register. `pend` drives the encoder's d inputs.
- Presents the highest-priority pending index (bit 7 highest, same priority as the encoder) on a valid/ready handshake.
- Clears the served pending bit on acceptance.

Parameters:
- SYNC_STAGES, 2, depth of the input synchronizer flops per request bit (legal 2..3).
- EDGE_MODE, 1, 1 = capture rising edges of synchronized req; 0 = capture level (pend set every cycle the synchronized bit is high).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  asynchronous request lines; bit 7 highest priority.
- en  input  1  presentation enable; capture continues while low.
- ready  input  1  consumer accepts the presented code.
- clr_ovf  input  1  synchronous clear of all overflow flags.
- pend  output  8  registered pending mask; feeds the encoder d inputs.
- code  output  3  registered index of the presented request.
- valid  output  1  code is valid.
- ovf  output  8  sticky per-bit overflow flags.

Behaviour:
- Reset: rst_n low asynchronously clears sync chains, edge-history flops, pend, code, valid, ovf and state. State goes to IDLE.
- Because the sync chain resets to 0, a req bit held high through reset release produces exactly one captured edge (EDGE_MODE=1).
- Synchronizer: SYNC_STAGES flops per bit. The edge detect compares the last sync stage with a history flop.
- Latency (SYNC_STAGES=2, EDGE_MODE=1): req rising before clk edge 1 -> pend bit set after edge 3 -> valid high after edge 4 if IDLE and en=1.
- Pending set/clear: pend[i] sets on a captured edge of bit i. It clears only on handshake acceptance of code i.
- Set and clear of the same bit in the same cycle: set wins, so the bit stays pending.
- Overflow: a captured edge on bit i while pend[i]=1 and not being cleared that cycle sets ovf[i].
- ovf bits are sticky. clr_ovf clears all bits; a simultaneous new overflow set wins for that bit.
- FSM state IDLE:
  - valid=0.
  - If en=1 and pend!=0, register code = index of the highest set pend bit, set valid=1, go to PRESENT.
  - Otherwise remain in IDLE.
- FSM state PRESENT:
  - valid=1 and code held stable regardless of en, req or higher-priority arrivals. No preemption once presented.
  - On valid&ready at a clock edge: clear pend[code] (subject to set-wins), drop valid, return to IDLE.
- Throughput: at most one transfer per two cycles. There is a mandatory IDLE cycle between transfers.
- ready while valid=0 is ignored.
- en deasserted in PRESENT does not drop valid. en low in IDLE blocks new presentation only.
- pend=0 in IDLE: valid stays 0 and code holds its last value.
- Reset asserted mid-transfer: valid drops immediately (asynchronous) and all pending requests are lost.

Decomposition:
- Shared package:
  - N_REQ=8, CODE_W=3.
  - State encoding IDLE=1'b0, PRESENT=1'b1.
  - Function hi_index(8-bit) returning the 3-bit highest-set index. Bit 7 has highest priority; 0 is returned for an all-zero input.
- One sub-module, req_sync_edge: width-8 synchronizer plus edge/level detect, parameterized by SYNC_STAGES and EDGE_MODE. It outputs an 8-bit one-cycle capture strobe.
- FSM, pend, ovf and code registers live in the top.

Test Plan:
- Reset release with req=8'h00, en=1, ready=0 -> pend=0, valid=0, code=0, ovf=0 for 10 cycles. Then pulse req[2] for 1 cycle -> pend=8'h04 after edge 3, valid=1 and code=3'd2 after edge 4.
- Set pend=8'h24 (bits 5,2) with ready=1 -> code 5 accepted first, one IDLE cycle, then code 2. pend goes 8'h24 -> 8'h04 -> 8'h00 and valid ends at 0.
- Code 1 in PRESENT with ready=0, then req[7] rises -> code stays 1 until accepted. The next presentation is code 7.
- en=0 while req[6] pulses -> pend=8'h40 and valid=0. Raise en -> valid=1 and code=6 on the next edge.
- Present code 3 and accept it in the same cycle a new req[3] edge is captured -> pend[3] stays 1, ovf[3] stays 0, and code 3 is re-presented after the IDLE cycle.
- Second req[4] edge while pend[4]=1 and unaccepted -> ovf=8'h10. clr_ovf pulse -> ovf=8'h00. Assert rst_n low mid-PRESENT -> valid=0 and pend=0 immediately.
